data_path: RTL and testbench
============================

# data_path

Parameterised datapath block: a 2^M × N register file with two read ports and one write port, operand bypass muxes, a 3-bit-opcode ALU, and a registered result/flag stage. The sequencer/control unit drives it one micro-operation per cycle. Register 2^M−1 serves as the program counter by convention only; the datapath treats it like any other register.

## Interface
- M, default 3: register address width (2^M registers)
- N, default 8: data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- din  in  N  external input data
- waddr  in  M  register-file write address
- ra  in  M  read address, port A
- rb  in  M  read address, port B
- op  in  3  ALU opcode
- ie  in  1  input enable: write data = din (else registered ALU result)
- write  in  1  register-file write enable
- reada  in  1  port A read enable
- readb  in  1  port B read enable
- en  in  1  ALU result/flag register load enable
- oe  in  1  output enable for dout
- offset  in  N  immediate operand
- bypassa  in  1  operand A = din instead of port A
- bypassb  in  1  operand B = offset instead of port B
- dout  out  N  result output
- o_flag, z_flag, n_flag  out  1 each  registered overflow/zero/negative flags

## Operation
- Read ports combinational: QA = reada ? RF[ra] : 0; QB = readb ? RF[rb] : 0.
- Operands: A = bypassa ? din : QA; B = bypassb ? offset : QB.
- ALU (combinational, N-bit, wrap-around): 000 A+B; 001 A−B; 010 A&B; 011 A|B; 100 A^B; 101 ~A; 110 A (pass); 111 A+1.
- Flags from combinational result Y: z = (Y==0); n = Y[N−1]; o = two's-complement signed overflow for 000/001/111, 0 for all other ops.
- Result register R and flag registers load Y/flags on rising edge when en=1; hold otherwise.
- Write data WD = ie ? din : R. On rising edge with write=1, RF[waddr] ← WD. write=0: no change.
- dout = oe ? R : 0 (no tri-state).
- o_flag/z_flag/n_flag driven directly from flag registers.

## Timing
- rst=1: immediately clears all RF entries, R, and all flags to 0, regardless of clock; dout = 0. Reset mid-operation discards any pending write or load.
- Read latency 0 (combinational). ALU result visible on dout/flags 1 cycle after the en edge.
- Same-edge write + read of same address: read returns old value; new value visible after the edge.
- Same edge with write=1, ie=0, en=1: RF gets the R value from before the edge; R gets the new Y. Back-to-back compute/write-back pipelines this way.
- Simultaneous write to the register being read as an operand: operand uses pre-edge contents.
- Deassertion of rst is effective at the next rising edge.

## Test plan
- Reset: hold rst, then release → all RF reads 0, dout=0 with oe=1, all flags 0.
- Load/add/write-back: ie=1 write din=0x01→R0, din=0x04→R1; ra=0, rb=1, op=000, en=1 → next cycle R=0x05, z=n=o=0; then write=1, ie=0, waddr=3 → RF[3]=0x05; oe=1 → dout=0x05.
- Subtract/flags: R0=0x01, R1=0x04, op=001 → R=0xFD, n=1, z=0; R0=R1=0x04 → R=0x00, z=1.
- Overflow: R0=0x7F, op=111 (inc) → R=0x80, o=1, n=1; op=000 with R0=0x80, R1=0x80 → R=0x00, o=1, z=1.
- Bypass: R0=0x01, bypassb=1, offset=0x10, op=000 → R=0x11; bypassa=1, din=0x22, op=110 → R=0x22; reada=readb=0, op=000 → R=0x00.
- Async reset mid-operation: assert rst between clock edges during a write/en cycle → RF, R, and flags clear immediately; no write occurs at the following edge.

Source files
------------

// File: rtl/data_path_if.sv
// Control/data bundle between the sequencer and the datapath.
// The sequencer owns the master side; the datapath implements the slave side.
interface data_path_if #(
  parameter int M = 3,
  parameter int N = 8
);
  logic [N-1:0] din;
  logic [M-1:0] waddr;
  logic [M-1:0] ra;
  logic [M-1:0] rb;
  logic [2:0]   op;
  logic         ie;
  logic         write;
  logic         reada;
  logic         readb;
  logic         en;
  logic         oe;
  logic [N-1:0] offset;
  logic         bypassa;
  logic         bypassb;
  logic [N-1:0] dout;
  logic         o_flag;
  logic         z_flag;
  logic         n_flag;

  modport master (
    output din, waddr, ra, rb, op, ie, write, reada, readb, en, oe,
           offset, bypassa, bypassb,
    input  dout, o_flag, z_flag, n_flag
  );

  modport slave (
    input  din, waddr, ra, rb, op, ie, write, reada, readb, en, oe,
           offset, bypassa, bypassb,
    output dout, o_flag, z_flag, n_flag
  );
endinterface

// File: rtl/data_path.sv
// 2^M x N register file (2R/1W), operand bypass muxes, 8-op ALU and a
// registered result/flag stage. One micro-op per clock from the sequencer.
// The top register is the PC only by software convention; no special casing.

// One register-file entry; loads on its own write strobe.
module data_path_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  // entry storage, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module data_path #(
  parameter int M = 3,
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  data_path_if.slave bus
);
  localparam int          NREGS  = 1 << M;
  localparam logic [N-1:0] ONE   = N'(1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_INC  = 3'b111;

  logic [NREGS-1:0][N-1:0] rf_q;
  logic [NREGS-1:0]        rf_we;
  logic [N-1:0]            wd;
  logic [N-1:0]            qa, qb;
  logic [N-1:0]            a, b;
  logic [N-1:0]            y;
  logic                    y_o;
  logic [N-1:0]            r_q;
  logic                    o_q, z_q, n_q;

  // Write-back takes the pre-edge R, so compute and write-back of the
  // previous result can share one edge.
  assign wd = bus.ie ? bus.din : r_q;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_rf
      assign rf_we[gi] = bus.write && (bus.waddr == M'(gi));
      data_path_reg #(.N(N)) u_reg (
        .clk (clk),
        .rst (rst),
        .we  (rf_we[gi]),
        .d   (wd),
        .q   (rf_q[gi])
      );
    end
  endgenerate

  // Read ports are combinational and see pre-edge contents on a same-edge write.
  assign qa = bus.reada ? rf_q[bus.ra] : '0;
  assign qb = bus.readb ? rf_q[bus.rb] : '0;
  assign a  = bus.bypassa ? bus.din    : qa;
  assign b  = bus.bypassb ? bus.offset : qb;

  // ALU with signed-overflow detection for the arithmetic ops only
  always_comb begin
    y   = '0;
    y_o = 1'b0;
    case (bus.op)
      OP_ADD: begin
        y   = a + b;
        y_o = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
      end
      OP_SUB: begin
        y   = a - b;
        y_o = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      OP_PASS: y = a;
      OP_INC: begin
        y   = a + ONE;
        y_o = !a[N-1] && y[N-1];
      end
      default: y = '0;
    endcase
  end

  // result and flag registers, loaded only when the sequencer asks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      o_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else if (bus.en) begin
      r_q <= y;
      o_q <= y_o;
      z_q <= (y == '0);
      n_q <= y[N-1];
    end
  end

  assign bus.dout   = bus.oe ? r_q : '0;
  assign bus.o_flag = o_q;
  assign bus.z_flag = z_q;
  assign bus.n_flag = n_q;
endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: stimulus pushes expected dout/flags with a
// due time into a queue; an independent monitor pops and compares.
module tb_data_path;
  logic clk;
  logic rst;

  data_path_if #(.M(3), .N(8)) bus ();

  data_path #(.M(3), .N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] d;
    logic       o;
    logic       z;
    logic       n;
    time        due;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic push(input string nm, input logic [7:0] d, input logic o,
                      input logic z, input logic n, input int dt);
    exp_t e;
    e.name = nm; e.d = d; e.o = o; e.z = z; e.n = n;
    e.due  = $time + dt;
    exp_q.push_back(e);
  endtask

  // monitor: compare every expectation whose sample time has arrived
  initial begin
    exp_t e;
    forever begin
      #1;
      while (exp_q.size() > 0 && exp_q[0].due <= $time) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.dout !== e.d || bus.o_flag !== e.o ||
            bus.z_flag !== e.z || bus.n_flag !== e.n) begin
          n_fail++;
          $display("FAIL %s: got dout=%h o=%b z=%b n=%b, want dout=%h o=%b z=%b n=%b",
                   e.name, bus.dout, bus.o_flag, bus.z_flag, bus.n_flag,
                   e.d, e.o, e.z, e.n);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_ctl();
    bus.din = '0; bus.waddr = '0; bus.ra = '0; bus.rb = '0; bus.op = 3'b000;
    bus.ie = 1'b0; bus.write = 1'b0; bus.reada = 1'b1; bus.readb = 1'b1;
    bus.en = 1'b0; bus.oe = 1'b1; bus.offset = '0;
    bus.bypassa = 1'b0; bus.bypassb = 1'b0;
  endtask

  task automatic wr(input logic [2:0] adr, input logic [7:0] v);
    idle_ctl();
    bus.ie = 1'b1; bus.write = 1'b1; bus.waddr = adr; bus.din = v;
    tick();
  endtask

  task automatic set_ops(input logic [2:0] ra_, input logic [2:0] rb_,
                         input logic [2:0] op_, input logic bpa,
                         input logic [7:0] di, input logic bpb,
                         input logic [7:0] off);
    idle_ctl();
    bus.ra = ra_; bus.rb = rb_; bus.op = op_;
    bus.bypassa = bpa; bus.din = di; bus.bypassb = bpb; bus.offset = off;
    bus.en = 1'b1;
  endtask

  // drive an ALU op with load enabled; result checked just after the edge
  task automatic alu_set(input string nm, input logic [2:0] ra_,
                         input logic [2:0] rb_, input logic [2:0] op_,
                         input logic bpa, input logic [7:0] di,
                         input logic bpb, input logic [7:0] off,
                         input logic [7:0] ed, input logic eo,
                         input logic ez, input logic en_);
    set_ops(ra_, rb_, op_, bpa, di, bpb, off);
    push(nm, ed, eo, ez, en_, 6);
  endtask

  task automatic alu(input string nm, input logic [2:0] ra_,
                     input logic [2:0] rb_, input logic [2:0] op_,
                     input logic bpa, input logic [7:0] di,
                     input logic bpb, input logic [7:0] off,
                     input logic [7:0] ed, input logic eo,
                     input logic ez, input logic en_);
    alu_set(nm, ra_, rb_, op_, bpa, di, bpb, off, ed, eo, ez, en_);
    tick();
  endtask

  // read a register through the pass op
  task automatic rd(input string nm, input logic [2:0] adr, input logic [7:0] ev);
    alu(nm, adr, 3'd0, 3'b110, 1'b0, 8'h00, 1'b0, 8'h00,
        ev, 1'b0, (ev == 8'h00), ev[7]);
  endtask

  initial begin
    int guard;
    idle_ctl();
    rst = 1'b1;
    tick();
    push("reset_state", 8'h00, 1'b0, 1'b0, 1'b0, 1);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) rd($sformatf("reset_rf%0d", i), 3'(i), 8'h00);

    // load, add, write-back
    wr(3'd0, 8'h01);
    wr(3'd1, 8'h04);
    alu("add_1_4", 3'd0, 3'd1, 3'b000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
    idle_ctl();
    bus.write = 1'b1; bus.ie = 1'b0; bus.waddr = 3'd3;
    push("wb_hold", 8'h05, 1'b0, 1'b0, 1'b0, 6);
    tick();
    rd("wb_r3", 3'd3, 8'h05);

    // compute and write-back on the same edge: RF[4] gets old R
    alu_set("pipe_sub", 3'd0, 3'd1, 3'b001, 1'b0, 8'h00, 1'b0, 8'h00, 8'hFD, 1'b0, 1'b0, 1'b1);
    bus.write = 1'b1; bus.ie = 1'b0; bus.waddr = 3'd4;
    tick();
    rd("pipe_r4", 3'd4, 8'h05);

    wr(3'd0, 8'h04);
    alu("sub_zero", 3'd0, 3'd1, 3'b001, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // same-edge write and read of R0 sees the old value
    alu_set("rw_same", 3'd0, 3'd0, 3'b110, 1'b0, 8'h00, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0);
    bus.write = 1'b1; bus.ie = 1'b1; bus.waddr = 3'd0; bus.din = 8'h7F;
    tick();
    alu("inc_ovf", 3'd0, 3'd0, 3'b111, 1'b0, 8'h00, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1);

    wr(3'd0, 8'h80);
    wr(3'd1, 8'h80);
    alu("add_ovf", 3'd0, 3'd1, 3'b000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

    // bypass paths and disabled read ports
    wr(3'd0, 8'h01);
    alu("byp_b", 3'd0, 3'd1, 3'b000, 1'b0, 8'h00, 1'b1, 8'h10, 8'h11, 1'b0, 1'b0, 1'b0);
    alu("byp_a", 3'd0, 3'd1, 3'b110, 1'b1, 8'h22, 1'b0, 8'h00, 8'h22, 1'b0, 1'b0, 1'b0);
    alu_set("no_read", 3'd0, 3'd1, 3'b000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    bus.reada = 1'b0; bus.readb = 1'b0;
    tick();

    // logic ops on A=3C, B=0F
    alu("and", 3'd0, 3'd0, 3'b010, 1'b1, 8'h3C, 1'b1, 8'h0F, 8'h0C, 1'b0, 1'b0, 1'b0);
    alu("or",  3'd0, 3'd0, 3'b011, 1'b1, 8'h3C, 1'b1, 8'h0F, 8'h3F, 1'b0, 1'b0, 1'b0);
    alu("xor", 3'd0, 3'd0, 3'b100, 1'b1, 8'h3C, 1'b1, 8'h0F, 8'h33, 1'b0, 1'b0, 1'b0);
    alu("not", 3'd0, 3'd0, 3'b101, 1'b1, 8'h3C, 1'b1, 8'h0F, 8'hC3, 1'b0, 1'b0, 1'b1);
    alu("sub_ovf", 3'd0, 3'd0, 3'b001, 1'b1, 8'h80, 1'b1, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0);

    // en=0 holds R/flags; oe=0 forces dout low but leaves flags
    idle_ctl();
    bus.op = 3'b000; bus.bypassa = 1'b1; bus.din = 8'h99;
    push("en_hold", 8'h7F, 1'b1, 1'b0, 1'b0, 6);
    tick();
    idle_ctl();
    bus.oe = 1'b0;
    push("oe_off", 8'h00, 1'b1, 1'b0, 1'b0, 6);
    tick();

    // async reset between edges during a write + load cycle
    alu("pre_arst", 3'd0, 3'd0, 3'b110, 1'b1, 8'h55, 1'b0, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0);
    set_ops(3'd0, 3'd0, 3'b110, 1'b1, 8'hAA, 1'b0, 8'h00);
    bus.write = 1'b1; bus.ie = 1'b1; bus.waddr = 3'd2;
    #1 rst = 1'b1;
    push("arst_immediate", 8'h00, 1'b0, 1'b0, 1'b0, 1);
    push("arst_edge", 8'h00, 1'b0, 1'b0, 1'b0, 5);
    tick();
    rst = 1'b0;
    rd("arst_r2", 3'd2, 8'h00);
    rd("arst_r0", 3'd0, 8'h00);
    rd("arst_r1", 3'd1, 8'h00);
    idle_ctl();

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
